multi_cycle_mips: RTL and testbench

Multi-cycle MIPS32-subset processor with one unified word-addressed instruction/data memory and no external bus. Each instruction runs through a state-machine sequence of 3–5 cycles. This is the top-level CPU block. Benches load programs by preloading the internal memory and observe progress through the hierarchical `pc` register and `mem.mem_data` array.

---
 rtl/multi_cycle_mips.sv | 180 ++++++++++++++++++
 tb/tb_multi_cycle_mips.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS32-subset CPU with a unified 1024-word memory, 3-5 cycles per instruction.
// No handshake: the core free-runs from PC 0 after reset and never stalls.

module mips_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem_data [0:1023];

  assign rdata = mem_data[word_addr];

  always_ff @(posedge clk) begin
    if (we) mem_data[word_addr] <= wdata;
  end
endmodule

module multi_cycle_mips (
  input logic clk,
  input logic reset
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB,
    IEXEC, IWB, BRANCH, JUMP, JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_LW = 6'h23;
  localparam logic [5:0] FN_JR = 6'h08;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] regs [0:31];
  logic [31:0] mem_rdata, alu_res, sext_imm, zext_imm, rs_val, rt_val, rf_wd;
  logic [9:0]  mem_word;
  logic [4:0]  rf_wa;
  logic        rf_we, mem_we, r_alu_fn, taken;

  wire [5:0] op     = ir[31:26];
  wire [4:0] rs     = ir[25:21];
  wire [4:0] rt     = ir[20:16];
  wire [4:0] rd     = ir[15:11];
  wire [4:0] shamt  = ir[10:6];
  wire [5:0] funct  = ir[5:0];

  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign zext_imm = {16'h0, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : regs[rt];
  assign mem_word = (state == FETCH) ? pc[11:2] : alu_out[11:2];
  assign mem_we   = (state == MEMWR) && !reset;
  assign taken    = ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));

  mips_mem mem (
    .clk       (clk),
    .we        (mem_we),
    .word_addr (mem_word),
    .wdata     (b),
    .rdata     (mem_rdata)
  );

  always_comb begin
    case (funct)
      6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: r_alu_fn = 1'b1;
      default:                                   r_alu_fn = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = a + sext_imm;
    if (op == OP_RTYPE) begin
      case (funct)
        6'h20, 6'h21: alu_res = a + b;
        6'h22, 6'h23: alu_res = a - b;
        6'h24:        alu_res = a & b;
        6'h25:        alu_res = a | b;
        6'h26:        alu_res = a ^ b;
        6'h27:        alu_res = ~(a | b);
        6'h2A:        alu_res = {31'd0, $signed(a) < $signed(b)};
        6'h2B:        alu_res = {31'd0, a < b};
        6'h00:        alu_res = b << shamt;
        6'h02:        alu_res = b >> shamt;
        6'h03:        alu_res = $signed(b) >>> shamt;
        default:      alu_res = 32'h0;
      endcase
    end else begin
      case (op)
        6'h0A:   alu_res = {31'd0, $signed(a) < $signed(sext_imm)};
        6'h0B:   alu_res = {31'd0, a < sext_imm};
        6'h0C:   alu_res = a & zext_imm;
        6'h0D:   alu_res = a | zext_imm;
        6'h0E:   alu_res = a ^ zext_imm;
        6'h0F:   alu_res = {ir[15:0], 16'h0};
        default: alu_res = a + sext_imm;
      endcase
    end
  end

  always_comb begin
    state_nxt = FETCH;
    rf_we     = 1'b0;
    rf_wa     = rt;
    rf_wd     = alu_out;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        // Unsupported encodings pass through BRANCH, where the condition can never hold.
        case (op)
          OP_RTYPE: begin
            if (funct == FN_JR)  state_nxt = JR;
            else if (r_alu_fn)   state_nxt = RTEXEC;
            else                 state_nxt = BRANCH;
          end
          6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E, 6'h0F: state_nxt = IEXEC;
          6'h23, 6'h2B:               state_nxt = MEMADR;
          6'h02, 6'h03:               state_nxt = JUMP;
          default:                    state_nxt = BRANCH;
        endcase
      end
      MEMADR: state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      RTEXEC: state_nxt = RTWB;
      IEXEC:  state_nxt = IWB;
      MEMWB: begin
        rf_we = 1'b1;
        rf_wd = mdr;
      end
      RTWB: begin
        rf_we = 1'b1;
        rf_wa = rd;
      end
      IWB:  rf_we = 1'b1;
      JUMP: begin
        rf_we = (op == OP_JAL);
        rf_wa = 5'd31;
        rf_wd = pc;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= 32'h0;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + {sext_imm[29:0], 2'b00};
        end
        MEMADR, RTEXEC, IEXEC: alu_out <= alu_res;
        MEMRD:  mdr <= mem_rdata;
        BRANCH: if (taken) pc <= alu_out;
        JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        JR:     pc <= a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && !reset && (rf_wa != 5'd0)) regs[rf_wa] <= rf_wd;
  end
endmodule

// File: tb/tb_multi_cycle_mips.sv
// Random-program bench: an instruction-level reference interpreter predicts every visible
// pc change (value and cycle) and the final memory image, including a reset during a store.

module tb_multi_cycle_mips;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_cycle_mips dut (.clk(clk), .reset(reset));

  typedef struct { logic [31:0] pc; int cyc; } ev_t;
  ev_t         exp_q[$];
  logic [31:0] mm [0:1023];
  logic [31:0] rr [0:31];
  logic [31:0] prev_pc;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;

  logic [5:0] rfn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                           6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  // Monitor: cycle k is the k-th rising edge after reset released; pops on every pc change.
  initial begin : monitor
    bit  rst_s;
    ev_t e;
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      if (rst_s) cyc = 0;
      else begin
        cyc++;
        if (mon_en && dut.pc !== prev_pc) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pc_event unexpected: pc=%h at cycle %0d, no change expected", dut.pc, cyc);
          end else begin
            e = exp_q.pop_front();
            if (dut.pc !== e.pc || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL pc_event: got pc=%h at cycle %0d, want pc=%h at cycle %0d",
                       dut.pc, cyc, e.pc, e.cyc);
            end
          end
        end
      end
      prev_pc = dut.pc;
    end
  end

  task automatic push_ev(input logic [31:0] p, input int t);
    ev_t e;
    e.pc  = p;
    e.cyc = t;
    exp_q.push_back(e);
  endtask

  // Instruction-level interpreter over mm/rr; returns first store's start cycle and total cycles.
  task automatic run_model(output int sw_t, output int total);
    logic [31:0] pc, pc4, nxt, prevpc, ins, a, b, sx, zx, res, addr;
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d, sh, wa;
    logic        wr;
    int          tc, cpi, halts;
    pc = 0; prevpc = 0; tc = 1; halts = 0; sw_t = -1;
    for (int i = 0; i < 32; i++) rr[i] = 32'h0;
    for (int step = 0; step < 3000 && halts < 3; step++) begin
      ins = mm[pc[11:2]];
      op = ins[31:26]; s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
      sh = ins[10:6]; fn = ins[5:0];
      a = rr[s]; b = rr[t];
      sx = {{16{ins[15]}}, ins[15:0]};
      zx = {16'h0, ins[15:0]};
      pc4 = pc + 4; nxt = pc4; cpi = 3; wr = 1'b0; wa = t; res = 0;
      case (op)
        6'h00: begin
          wr = 1'b1; wa = d; cpi = 4;
          case (fn)
            6'h20, 6'h21: res = a + b;
            6'h22, 6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
            6'h2B: res = (a < b) ? 1 : 0;
            6'h00: res = b << sh;
            6'h02: res = b >> sh;
            6'h03: res = $signed(b) >>> sh;
            6'h08: begin wr = 1'b0; cpi = 3; nxt = a; end
            default: begin wr = 1'b0; cpi = 3; end
          endcase
        end
        6'h08, 6'h09: begin wr = 1'b1; cpi = 4; res = a + sx; end
        6'h0A: begin wr = 1'b1; cpi = 4; res = ($signed(a) < $signed(sx)) ? 1 : 0; end
        6'h0B: begin wr = 1'b1; cpi = 4; res = (a < sx) ? 1 : 0; end
        6'h0C: begin wr = 1'b1; cpi = 4; res = a & zx; end
        6'h0D: begin wr = 1'b1; cpi = 4; res = a | zx; end
        6'h0E: begin wr = 1'b1; cpi = 4; res = a ^ zx; end
        6'h0F: begin wr = 1'b1; cpi = 4; res = zx << 16; end
        6'h23: begin addr = a + sx; wr = 1'b1; cpi = 5; res = mm[addr[11:2]]; end
        6'h2B: begin
          addr = a + sx; cpi = 4; mm[addr[11:2]] = b;
          if (sw_t < 0) sw_t = tc;
        end
        6'h04: if (a == b) nxt = pc4 + (sx << 2);
        6'h05: if (a != b) nxt = pc4 + (sx << 2);
        6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
        6'h03: begin nxt = {pc4[31:28], ins[25:0], 2'b00}; wr = 1'b1; wa = 5'd31; res = pc4; end
        default: ;
      endcase
      if (wr && wa != 5'd0) rr[wa] = res;
      if (pc4 != prevpc) push_ev(pc4, tc);
      if (nxt != pc4) push_ev(nxt, tc + cpi - 1);
      if (nxt == pc) halts++;
      prevpc = nxt; pc = nxt; tc += cpi;
    end
    total = tc;
  endtask

  // Random preload, register init, random body (or a single store), register dump, halt loop.
  task automatic gen_program(input bit rst_test);
    int w, k, tw;
    logic [4:0] r1, r2, r3;
    for (int i = 0; i < 1024; i++) mm[i] = $urandom;
    w = 0;
    for (int r = 1; r < 32; r++) begin
      mm[w]     = enc_i(6'h0F, 5'd0, 5'(r), 16'($urandom));
      mm[w + 1] = enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom));
      w += 2;
    end
    if (rst_test) begin
      mm[w] = enc_i(6'h2B, 5'd0, 5'($urandom_range(1, 31)), 16'h0900);
      w++;
    end else begin
      while (w < 102) begin
        k = $urandom_range(0, 10);
        r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
        case (k)
          0, 1, 2: mm[w] = enc_r(r1, r2, r3, 5'($urandom), rfn[$urandom_range(0, 12)]);
          3, 4:    mm[w] = enc_i(6'h08 + 6'($urandom_range(0, 7)), r1, r2, 16'($urandom));
          5:       mm[w] = enc_i(6'h23, 5'd0, r2, 16'(32'h800 + 4 * $urandom_range(0, 63)));
          6:       mm[w] = enc_i(6'h2B, 5'd0, r2, 16'(32'h800 + 4 * $urandom_range(0, 63)));
          7: mm[w] = enc_i(6'h04 + 6'($urandom_range(0, 1)), r1,
                           ($urandom_range(0, 1) != 0) ? r1 : r2, 16'($urandom_range(0, 3)));
          8: begin
            tw = w + 1 + $urandom_range(0, 3);
            mm[w] = {6'h02 + 6'($urandom_range(0, 1)), 26'(tw)};
          end
          9: begin
            r1 = 5'($urandom_range(1, 31));
            mm[w]     = enc_i(6'h0F, 5'd0, r1, 16'h0);
            mm[w + 1] = enc_i(6'h0D, r1, r1, 16'((w + 4) * 4));
            mm[w + 2] = enc_r(r1, 5'd0, 5'd0, 5'd0, 6'h08);
            mm[w + 3] = {6'h3F, 26'($urandom)};
            w += 3;
          end
          default: mm[w] = ($urandom_range(0, 1) != 0) ? {6'h3F, 26'($urandom)}
                                                       : enc_r(r1, r2, r3, 5'd0, 6'h3F);
        endcase
        w++;
      end
    end
    for (int r = 0; r < 32; r++) begin
      mm[w] = enc_i(6'h2B, 5'd0, 5'(r), 16'(32'hA00 + 4 * r));
      w++;
    end
    mm[w] = {6'h02, 26'(w)};
  endtask

  task automatic load_dut();
    for (int i = 0; i < 1024; i++) dut.mem.mem_data[i] = mm[i];
  endtask

  task automatic check_pc_zero(input string name);
    n_tests++;
    if (dut.pc !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: pc=%h, want 00000000", name, dut.pc);
    end
  endtask

  // Runs from reset release until every predicted event is seen, then compares all memory.
  task automatic run_and_check(input int budget, input string name);
    int waited, bad, first;
    waited = 0; bad = 0; first = -1;
    mon_en = 1'b1;
    reset  = 1'b0;
    while (exp_q.size() > 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    mon_en = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d pc events still pending after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
    for (int i = 0; i < 1024; i++) begin
      if (dut.mem.mem_data[i] !== mm[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s memory: %0d words differ, first mem_data[%0d]=%h want %h",
               name, bad, first, dut.mem.mem_data[first], mm[first]);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    int sw_t, total, waited;
    logic [31:0] pre;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_pc_zero("reset_pc");

    for (int n = 0; n < 6; n++) begin
      gen_program(1'b0);
      load_dut();
      run_model(sw_t, total);
      run_and_check(total + 40, $sformatf("random_prog%0d", n));
    end

    // Reset lands on the MEMWR edge of the first store: word unchanged, pc back to 0.
    gen_program(1'b1);
    load_dut();
    pre = mm[576];
    run_model(sw_t, total);
    reset = 1'b0;
    waited = 0;
    while (cyc < sw_t + 2 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dut.mem.mem_data[576] !== pre) begin
      n_fail++;
      $display("FAIL reset_mid_store: mem_data[576]=%h, want unchanged %h", dut.mem.mem_data[576], pre);
    end
    check_pc_zero("reset_mid_pc");
    run_and_check(total + 40, "reset_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
